ibex_ahb_bus_arbiter: RTL
=========================

Name: ibex_ahb_bus_arbiter

Overview:
- Shares one AHB-Lite master port between the Ibex instruction-fetch and data-LSU request/grant/rvalid interfaces.
- Sequences each transfer as an AHB address phase followed by a data phase.
- Data accesses have priority; a starvation counter bounds instruction-fetch latency.
- Byte enables are translated to HSIZE and the HADDR[1:0] offset, and AHB errors are returned to the core.
- Sits between ibex_core and the AHB interconnect inside the processor wrapper.

Parameters:
- STARVE_MAX, 4, number of consecutive data grants made while instr_req_i is pending before one instruction grant is forced (1..15).

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address (word aligned)
- instr_gnt_o  out  1  fetch accepted
- instr_rvalid_o  out  1  fetch data valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch bus error, qualified by instr_rvalid_o
- data_req_i  in  1  load/store request
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address (word aligned)
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  data accepted
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  load data
- data_err_o  out  1  data error, qualified by data_rvalid_o
- HADDR  out  32  AHB address
- HSIZE  out  3  AHB size
- HTRANS  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
- HWRITE  out  1  AHB write
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB error response

Behaviour:

Clock and reset:
- One clock, HCLK. Reset is asynchronous and active-low on HRESETn.
- Reset values: state=IDLE, HTRANS=00, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, all gnt/rvalid/err outputs 0, starve counter 0.

State machine: IDLE, DPH_I (instruction data phase), DPH_D (data data phase), BERR (illegal byte-enable response).

IDLE, address phase driven combinationally:
- Select data if data_req_i, unless instr_req_i=1 and starve counter == STARVE_MAX; in that case select instruction.
- Otherwise select instruction if instr_req_i.
- If a request is selected:
  - Drive HTRANS=10 with HADDR, HSIZE and HWRITE for it.
  - Pulse the matching gnt_o in the same cycle.
  - Next state is DPH_I or DPH_D.
- No request: HTRANS=00, stay in IDLE.
- Grants are issued only in IDLE.

Instruction address phase: HADDR = instr_addr_i, HSIZE=010, HWRITE=0.

Data address phase, HADDR = {data_addr_i[31:2], off}:
- be 0001/0010/0100/1000 → HSIZE=000, off = 00/01/10/11.
- be 0011/1100 → HSIZE=001, off = 00/10.
- be 1111 → HSIZE=010, off = 00.
- Any other be is illegal: data_gnt_o=1, HTRANS stays 00, next state BERR.

On a data grant, register data_wdata_i and data_we_i. The registered write data drives HWDATA for the whole DPH_D state.

DPH_x, data phase:
- HTRANS=00.
- Hold while HREADY=0.
- On the first cycle with HREADY=1:
  - Pulse the matching rvalid_o.
  - rdata_o = HRDATA.
  - err_o = HRESP.
  - Return to IDLE.
- The early HRESP of the two-cycle AHB error response (HREADY=0) is ignored; only the HREADY=1 cycle is sampled.
- Stores return rvalid with rdata don't-care.

BERR: for one cycle data_rvalid_o=1 and data_err_o=1; next state IDLE. No bus access is made.

Latency: minimum 2 cycles from req to rvalid (grant cycle + one data-phase cycle), plus one cycle per HREADY=0 wait state.

Starve counter (4 bit):
- Increments on each data grant made while instr_req_i=1, saturating at STARVE_MAX.
- Clears on any instruction grant.
- Clears on a data grant made while instr_req_i=0.

Boundary conditions:
- Simultaneous requests: data wins unless the counter is at STARVE_MAX.
- Requests arriving during DPH_x or BERR are not granted until IDLE.
- Reset mid-transfer aborts the transfer: no rvalid is generated, and the core is also reset.
- rdata_o mirrors HRDATA and is valid only with rvalid.

Test Plan:
1. Single fetch, zero wait: instr_req, addr 0x100, HRDATA=0x00500093 → gnt in cycle 0 with HTRANS=10, HADDR=0x100, HSIZE=010; instr_rvalid in cycle 1 with rdata=0x00500093.
2. Byte store: be=0100, addr 0x2000, wdata=0x00AB0000, two HREADY=0 waits → HADDR=0x2002, HSIZE=000, HWRITE=1; HWDATA=0x00AB0000 held 3 cycles; data_rvalid in cycle 3.
3. Contention, STARVE_MAX=4: both requests held continuously → grant order D,D,D,D,I,D…; starve counter returns to 0 after the instruction grant.
4. AHB error: load at 0x3000 with HRESP=1, HREADY=0 then HRESP=1, HREADY=1 → single data_rvalid with data_err=1 in the second data-phase cycle.
5. Illegal be=0110 → data_gnt=1 with HTRANS=00 throughout; next cycle data_rvalid=1, data_err=1; no AHB transfer occurs.
6. HRESETn low during DPH_D with HREADY=0 → outputs go to reset values immediately; no rvalid; after release a fresh fetch completes normally.

Source files
------------

// File: rtl/ibex_ahb_bus_arbiter.sv
// Shares one AHB-Lite master port between the Ibex fetch and LSU interfaces.
// Data wins arbitration; a saturating starve counter forces a fetch grant.
module ibex_ahb_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] HADDR,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [1:0]  dbg_state
);

  // Handshake: a grant pulses in the address-phase cycle (IDLE only); exactly
  // one rvalid follows per grant, on the first data-phase cycle with HREADY=1.
  typedef enum logic [1:0] {IDLE, DPH_I, DPH_D, BERR} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        starve_full, sel_d, sel_i;
  logic        be_ok;
  logic [1:0]  off;
  logic [2:0]  dsize;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^data_addr_i[1:0];
  assign dbg_state        = state_q;
  assign starve_full      = (starve_q == 4'(STARVE_MAX));
  assign sel_d            = data_req_i && !(instr_req_i && starve_full);
  assign sel_i            = instr_req_i && !sel_d;

  always_comb begin
    be_ok = 1'b1;
    off   = 2'b00;
    dsize = 3'b000;
    case (data_be_i)
      4'b0001: begin dsize = 3'b000; off = 2'b00; end
      4'b0010: begin dsize = 3'b000; off = 2'b01; end
      4'b0100: begin dsize = 3'b000; off = 2'b10; end
      4'b1000: begin dsize = 3'b000; off = 2'b11; end
      4'b0011: begin dsize = 3'b001; off = 2'b00; end
      4'b1100: begin dsize = 3'b001; off = 2'b10; end
      4'b1111: begin dsize = 3'b010; off = 2'b00; end
      default: be_ok = 1'b0;
    endcase
  end

  // Outputs are gated by HRESETn so a reset mid-transfer quiets the bus at once.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    instr_gnt_o    = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    data_gnt_o     = 1'b0;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    instr_rdata_o  = HRDATA;
    data_rdata_o   = HRDATA;
    HTRANS         = 2'b00;
    HADDR          = 32'h0;
    HSIZE          = 3'b000;
    HWRITE         = 1'b0;
    HWDATA         = 32'h0;
    if (HRESETn) begin
      case (state_q)
        IDLE: begin
          if (sel_d) begin
            data_gnt_o = 1'b1;
            if (!instr_req_i)     starve_d = 4'd0;
            else if (!starve_full) starve_d = starve_q + 4'd1;
            if (be_ok) begin
              HTRANS  = 2'b10;
              HADDR   = {data_addr_i[31:2], off};
              HSIZE   = dsize;
              HWRITE  = data_we_i;
              state_d = DPH_D;
            end else begin
              state_d = BERR;
            end
          end else if (sel_i) begin
            instr_gnt_o = 1'b1;
            starve_d    = 4'd0;
            HTRANS      = 2'b10;
            HADDR       = instr_addr_i;
            HSIZE       = 3'b010;
            state_d     = DPH_I;
          end
        end
        DPH_I: begin
          if (HREADY) begin
            instr_rvalid_o = 1'b1;
            instr_err_o    = HRESP;
            state_d        = IDLE;
          end
        end
        DPH_D: begin
          HWDATA = we_q ? wdata_q : 32'h0;
          if (HREADY) begin
            data_rvalid_o = 1'b1;
            data_err_o    = HRESP;
            state_d       = IDLE;
          end
        end
        BERR: begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (data_gnt_o) begin
        wdata_q <= data_wdata_i;
        we_q    <= data_we_i;
      end
    end
  end

endmodule
